mreq_wb_master: RTL and testbench
=================================

// Module: mreq_wb_master
// PURPOSE
// Executes memory requests (MREQ) from the command receiver as Wishbone classic cycles.
// Writes take word data from a byte stream; reads return word data on a byte stream to the tx path.
// Sits between the command parser and the register/memory bus, one MREQ at a time.
// PARAMETERS
// ADDR_W     32    Wishbone word-address width; the low ADDR_W bits of MREQ addr are used.
// TMO_CYCLES 255   Cycles to wait for wb_ack before aborting one word (>=1).
// PORTS
// clk             in   1         clock, posedge
// rst             in   1         synchronous reset, active-high
// i_mreq_valid    in   1         MREQ offered
// o_mreq_ready    out  1         MREQ accepted when valid&&ready
// i_mreq          in   MREQ_NBIT packed MREQ (wr, aincr, wsize, wcount, addr); decoded with mreq_defines.vh helpers
// i_wdata         in   8         write-data byte
// i_wdata_valid   in   1         write byte offered
// o_wdata_ready   out  1         write byte accepted when valid&&ready
// o_rdata         out  8         read-data byte
// o_rdata_valid   out  1         read byte offered
// i_rdata_ready   in   1         read byte taken when valid&&ready
// o_wb_cyc/o_wb_stb out 1        Wishbone cycle/strobe (always equal)
// o_wb_we         out  1         Wishbone write enable
// o_wb_adr        out  ADDR_W    Wishbone word address
// o_wb_dat        out  32        Wishbone write data
// i_wb_dat        in   32        Wishbone read data
// i_wb_ack        in   1         Wishbone acknowledge
// o_err_timeout   out  1         one-cycle pulse per word that timed out
// o_busy          out  1         high in every state except ST_IDLE
// BEHAVIOUR
// - Reset: state ST_IDLE; all outputs 0 except o_mreq_ready=1; o_wb_adr/o_wb_dat/o_rdata 0.
// - Bytes per word NB: wsize 0->1, 1->2, 2->4, 3->4. Words N = wcount+1 (1..256). Little-endian bytes.
// - ST_IDLE: o_mreq_ready=1; on accept latch fields, adr<=addr[ADDR_W-1:0], word cnt<=wcount;
//   wr=1 -> ST_WR_COLLECT, wr=0 -> ST_RD_BUS. No bus activity in the accept cycle.
// - ST_WR_COLLECT: o_wdata_ready=1; each accepted byte k goes to o_wb_dat[8k+7:8k]; unused upper bytes 0;
//   after NB-th byte -> ST_WR_BUS next cycle.
// - ST_WR_BUS / ST_RD_BUS: cyc=stb=1, we=wr; timeout counter counts cycles with stb high and no ack.
//   i_wb_ack -> drop cyc/stb next cycle; read latches i_wb_dat. Counter reaching TMO_CYCLES without ack ->
//   drop cyc/stb, pulse o_err_timeout, read data forced to 0. ack in the same cycle as expiry counts as ack.
// - Reads then -> ST_RD_EMIT: byte k of the latched word on o_rdata, o_rdata_valid=1, held stable until taken;
//   after NB-th byte taken -> word done.
// - Word done: if cnt==0 -> ST_IDLE; else cnt-=1, adr+=1 if aincr (wraps modulo 2^ADDR_W), next word
//   (ST_WR_COLLECT or ST_RD_BUS).
// - Bus cycles are never back-to-back: cyc/stb low for at least one cycle between words.
// - o_wdata_ready is 0 outside ST_WR_COLLECT; o_rdata_valid is 0 outside ST_RD_EMIT.
// - rst mid-transfer: immediate return to ST_IDLE, cyc/stb dropped the following cycle, partial data discarded.
// - Timeout does not abort the MREQ: remaining words still execute, so byte counts on both streams stay framed.
// TESTING
// - Write wsize=2 wcount=0 addr=0x10, bytes 11 22 33 44 -> one WB write adr=0x10 dat=0x44332211, then idle, ready=1.
// - Read wsize=0 wcount=2 aincr=1 addr=0xFE, WB returns 0xA1,0xB2,0xC3 -> adr 0xFE,0xFF,0x100; bytes A1 B2 C3.
// - Read aincr=0 wcount=1 wsize=1, i_rdata_ready low 5 cycles -> o_rdata held stable, both words at same adr.
// - Read TMO_CYCLES=4, no ack -> stb high 4 cycles, one o_err_timeout pulse, bytes 00 emitted, returns to idle.
// - ADDR_W=8 aincr addr=0xFF wcount=1 write -> second word at adr 0x00 (wrap).
// - rst asserted during ST_WR_COLLECT after 2 of 4 bytes -> idle next cycle, no WB cycle issued, o_mreq_ready=1.

Source files
------------

// File: rtl/mreq_wb_master.sv
// Runs one memory request at a time as Wishbone classic cycles, moving word data
// through little-endian byte streams (write bytes in, read bytes out).
module mreq_wb_master #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned TMO_CYCLES = 255,
  // MREQ layout: {wr[43], aincr[42], wsize[41:40], wcount[39:32], addr[31:0]}
  localparam int unsigned MREQ_NBIT = 44
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_mreq_valid,
  output logic                 o_mreq_ready,
  input  logic [MREQ_NBIT-1:0] i_mreq,
  input  logic [7:0]           i_wdata,
  input  logic                 i_wdata_valid,
  output logic                 o_wdata_ready,
  output logic [7:0]           o_rdata,
  output logic                 o_rdata_valid,
  input  logic                 i_rdata_ready,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic                 o_wb_we,
  output logic [ADDR_W-1:0]    o_wb_adr,
  output logic [31:0]          o_wb_dat,
  input  logic [31:0]          i_wb_dat,
  input  logic                 i_wb_ack,
  output logic                 o_err_timeout,
  output logic                 o_busy
);

  localparam int unsigned TMO_W      = (TMO_CYCLES < 2) ? 1 : $clog2(TMO_CYCLES);
  localparam int unsigned BIT_WR     = 43;
  localparam int unsigned BIT_AINCR  = 42;
  localparam int unsigned WSIZE_LSB  = 40;
  localparam int unsigned WCOUNT_LSB = 32;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_COLLECT, ST_WR_BUS, ST_RD_BUS, ST_RD_EMIT
  } state_t;

  state_t              state_q, state_d;
  logic                wr_q, wr_d, aincr_q, aincr_d;
  logic [1:0]          wsize_q, wsize_d, k_q, k_d, last_k;
  logic [7:0]          cnt_q, cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [31:0]         rword_q, rword_d, dat_q, dat_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                cyc_q, cyc_d, we_q, we_d, mready_q, mready_d;
  logic                wready_q, wready_d, rvalid_q, rvalid_d;
  logic                busy_q, busy_d, err_q, err_d;
  logic                bus_done, word_done;

  // Address bits above ADDR_W are intentionally ignored.
  logic unused_mreq_addr;
  assign unused_mreq_addr = ^i_mreq[31:0];

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_q     <= 1'b0;
      aincr_q  <= 1'b0;
      wsize_q  <= 2'd0;
      k_q      <= 2'd0;
      cnt_q    <= 8'd0;
      tmo_q    <= '0;
      rword_q  <= 32'd0;
      dat_q    <= 32'd0;
      adr_q    <= '0;
      rdata_q  <= 8'd0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      mready_q <= 1'b1;
      wready_q <= 1'b0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      aincr_q  <= aincr_d;
      wsize_q  <= wsize_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      rword_q  <= rword_d;
      dat_q    <= dat_d;
      adr_q    <= adr_d;
      rdata_q  <= rdata_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      mready_q <= mready_d;
      wready_q <= wready_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Next state, datapath and output decode
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    aincr_d   = aincr_q;
    wsize_d   = wsize_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    rword_d   = rword_q;
    dat_d     = dat_q;
    adr_d     = adr_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    bus_done  = 1'b0;
    word_done = 1'b0;
    case (wsize_q)
      2'd0:    last_k = 2'd0;
      2'd1:    last_k = 2'd1;
      default: last_k = 2'd3;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (i_mreq_valid) begin
          wr_d    = i_mreq[BIT_WR];
          aincr_d = i_mreq[BIT_AINCR];
          wsize_d = i_mreq[WSIZE_LSB +: 2];
          cnt_d   = i_mreq[WCOUNT_LSB +: 8];
          adr_d   = i_mreq[ADDR_W-1:0];
          k_d     = 2'd0;
          tmo_d   = '0;
          dat_d   = 32'd0;
          state_d = i_mreq[BIT_WR] ? ST_WR_COLLECT : ST_RD_BUS;
        end
      end
      ST_WR_COLLECT: begin
        if (i_wdata_valid) begin
          dat_d[{k_q, 3'b000} +: 8] = i_wdata;
          k_d = 2'(k_q + 2'd1);
          if (k_q == last_k) begin
            k_d     = 2'd0;
            tmo_d   = '0;
            state_d = ST_WR_BUS;
          end
        end
      end
      ST_WR_BUS, ST_RD_BUS: begin
        // Ack on the expiry cycle wins over the timeout
        if (i_wb_ack) begin
          rword_d  = i_wb_dat;
          bus_done = 1'b1;
        end else if (tmo_q == TMO_W'(TMO_CYCLES - 1)) begin
          rword_d  = 32'd0;
          err_d    = 1'b1;
          bus_done = 1'b1;
        end else begin
          tmo_d = TMO_W'(tmo_q + 1'b1);
        end
        if (bus_done) begin
          if (state_q == ST_WR_BUS) begin
            word_done = 1'b1;
          end else begin
            k_d     = 2'd0;
            state_d = ST_RD_EMIT;
          end
        end
      end
      ST_RD_EMIT: begin
        if (i_rdata_ready) begin
          if (k_q == last_k) word_done = 1'b1;
          else               k_d = 2'(k_q + 2'd1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (word_done) begin
      if (cnt_q == 8'd0) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d = 8'(cnt_q - 8'd1);
        if (aincr_q) adr_d = ADDR_W'(adr_q + 1'b1);
        k_d     = 2'd0;
        tmo_d   = '0;
        dat_d   = 32'd0;
        state_d = wr_q ? ST_WR_COLLECT : ST_RD_BUS;
      end
    end

    cyc_d    = (state_d == ST_WR_BUS) || (state_d == ST_RD_BUS);
    we_d     = (state_d == ST_WR_BUS);
    mready_d = (state_d == ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
    wready_d = (state_d == ST_WR_COLLECT);
    rvalid_d = (state_d == ST_RD_EMIT);
    if (state_d == ST_RD_EMIT) rdata_d = rword_d[{k_d, 3'b000} +: 8];
  end

  assign o_mreq_ready  = mready_q;
  assign o_wdata_ready = wready_q;
  assign o_rdata       = rdata_q;
  assign o_rdata_valid = rvalid_q;
  assign o_wb_cyc      = cyc_q;
  assign o_wb_stb      = cyc_q;
  assign o_wb_we       = we_q;
  assign o_wb_adr      = adr_q;
  assign o_wb_dat      = dat_q;
  assign o_err_timeout = err_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_mreq_wb_master.sv
// Scoreboard bench for mreq_wb_master: instance a (default params) and instance b
// (ADDR_W=8, TMO_CYCLES=4) share clock and reset.
module tb_mreq_wb_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; } wb_exp_t;
  wb_exp_t     exp_wb_a[$], exp_wb_b[$];
  logic [7:0]  exp_rd_a[$], exp_rd_b[$];
  logic [31:0] rdw_a[$], rdw_b[$];
  int checks = 0, failures = 0;

  // Instance a signals
  logic mvalid_a = 0, mready_a, wvalid_a = 0, wready_a, rvalid_a, rready_a = 1;
  logic [43:0] mreq_a = '0;
  logic [7:0]  wdata_a = '0, rdata_a;
  logic cyc_a, stb_a, we_a, ack_a = 0, err_a, busy_a;
  logic [31:0] adr_a, dat_a, wbdat_a = '0;
  // Instance b signals
  logic mvalid_b = 0, mready_b, wvalid_b = 0, wready_b, rvalid_b, rready_b = 1;
  logic [43:0] mreq_b = '0;
  logic [7:0]  wdata_b = '0, rdata_b;
  logic cyc_b, stb_b, we_b, ack_b = 0, err_b, busy_b;
  logic [7:0]  adr_b;
  logic [31:0] dat_b, wbdat_b = '0;

  mreq_wb_master u_a (
    .clk(clk), .rst(rst), .i_mreq_valid(mvalid_a), .o_mreq_ready(mready_a), .i_mreq(mreq_a),
    .i_wdata(wdata_a), .i_wdata_valid(wvalid_a), .o_wdata_ready(wready_a),
    .o_rdata(rdata_a), .o_rdata_valid(rvalid_a), .i_rdata_ready(rready_a),
    .o_wb_cyc(cyc_a), .o_wb_stb(stb_a), .o_wb_we(we_a), .o_wb_adr(adr_a), .o_wb_dat(dat_a),
    .i_wb_dat(wbdat_a), .i_wb_ack(ack_a), .o_err_timeout(err_a), .o_busy(busy_a));

  mreq_wb_master #(.ADDR_W(8), .TMO_CYCLES(4)) u_b (
    .clk(clk), .rst(rst), .i_mreq_valid(mvalid_b), .o_mreq_ready(mready_b), .i_mreq(mreq_b),
    .i_wdata(wdata_b), .i_wdata_valid(wvalid_b), .o_wdata_ready(wready_b),
    .o_rdata(rdata_b), .o_rdata_valid(rvalid_b), .i_rdata_ready(rready_b),
    .o_wb_cyc(cyc_b), .o_wb_stb(stb_b), .o_wb_we(we_b), .o_wb_adr(adr_b), .o_wb_dat(dat_b),
    .i_wb_dat(wbdat_b), .i_wb_ack(ack_b), .o_err_timeout(err_b), .o_busy(busy_b));

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [43:0] mk(input bit wr, input bit aincr, input logic [1:0] wsize,
                                     input logic [7:0] wcount, input logic [31:0] addr);
    return {wr, aincr, wsize, wcount, addr};
  endfunction

  // Wishbone responders: ack after dly extra cycles of stb, read data from a word queue
  bit ack_en_a = 1, ack_en_b = 1;
  int dly_a = 0, dly_b = 0, hi_a = 0, hi_b = 0, len_b = 0, err_cnt_a = 0, err_cnt_b = 0;
  always @(negedge clk) begin
    if (cyc_a === 1'b1) begin
      hi_a++;
      if (!ack_a && ack_en_a && hi_a > dly_a) begin
        ack_a = 1'b1;
        if (!we_a && rdw_a.size() > 0) wbdat_a = rdw_a.pop_front();
      end
    end else begin
      hi_a = 0; ack_a = 1'b0;
    end
    if (cyc_b === 1'b1) begin
      hi_b++;
      if (!ack_b && ack_en_b && hi_b > dly_b) begin
        ack_b = 1'b1;
        if (!we_b && rdw_b.size() > 0) wbdat_b = rdw_b.pop_front();
      end
    end else begin
      if (hi_b > 0) len_b = hi_b;
      hi_b = 0; ack_b = 1'b0;
    end
  end

  // Monitors: pop expectations on each bus cycle start and each byte handshake
  logic pcyc_a = 0, pcyc_b = 0, pv_a = 0, pt_a = 0, pv_b = 0, pt_b = 0;
  logic [7:0] pd_a = '0, pd_b = '0;
  always @(negedge clk) begin
    wb_exp_t e;
    if (err_a === 1'b1) err_cnt_a++;
    if (err_b === 1'b1) err_cnt_b++;
    if (cyc_a === 1'b1 && !pcyc_a) begin
      chk("a_stb_eq_cyc", {31'd0, stb_a}, 32'd1);
      if (exp_wb_a.size() == 0) chk("a_unexpected_wb_cycle", adr_a, 32'hFFFF_FFFF);
      else begin
        e = exp_wb_a.pop_front();
        chk("a_wb_we", {31'd0, we_a}, {31'd0, e.we});
        chk("a_wb_adr", adr_a, e.adr);
        if (e.we) chk("a_wb_dat", dat_a, e.dat);
      end
    end
    if (cyc_b === 1'b1 && !pcyc_b) begin
      if (exp_wb_b.size() == 0) chk("b_unexpected_wb_cycle", {24'd0, adr_b}, 32'hFFFF_FFFF);
      else begin
        e = exp_wb_b.pop_front();
        chk("b_wb_we", {31'd0, we_b}, {31'd0, e.we});
        chk("b_wb_adr", {24'd0, adr_b}, e.adr);
        if (e.we) chk("b_wb_dat", dat_b, e.dat);
      end
    end
    if (rvalid_a === 1'b1 && pv_a && !pt_a) chk("a_rdata_stable", {24'd0, rdata_a}, {24'd0, pd_a});
    if (rvalid_a === 1'b1 && rready_a) begin
      if (exp_rd_a.size() == 0) chk("a_unexpected_rbyte", {24'd0, rdata_a}, 32'hFFFF_FFFF);
      else chk("a_rbyte", {24'd0, rdata_a}, {24'd0, exp_rd_a.pop_front()});
    end
    if (rvalid_b === 1'b1 && rready_b) begin
      if (exp_rd_b.size() == 0) chk("b_unexpected_rbyte", {24'd0, rdata_b}, 32'hFFFF_FFFF);
      else chk("b_rbyte", {24'd0, rdata_b}, {24'd0, exp_rd_b.pop_front()});
    end
    pcyc_a = (cyc_a === 1'b1); pcyc_b = (cyc_b === 1'b1);
    pv_a = (rvalid_a === 1'b1); pt_a = pv_a && rready_a; pd_a = rdata_a;
    pv_b = (rvalid_b === 1'b1); pt_b = pv_b && rready_b; pd_b = rdata_b;
  end

  task automatic issue(input bit sel, input logic [43:0] m);
    int n = 0;
    if (sel) begin mreq_b = m; mvalid_b = 1; end else begin mreq_a = m; mvalid_a = 1; end
    while (!(sel ? mready_b : mready_a) && n < 1000) begin @(posedge clk); #1; n++; end
    if (n >= 1000) chk("mreq_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    mvalid_a = 0; mvalid_b = 0;
  endtask

  task automatic put_byte(input bit sel, input logic [7:0] b);
    int n = 0;
    if (sel) begin wdata_b = b; wvalid_b = 1; end else begin wdata_a = b; wvalid_a = 1; end
    while (!(sel ? wready_b : wready_a) && n < 1000) begin @(posedge clk); #1; n++; end
    if (n >= 1000) chk("wbyte_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    wvalid_a = 0; wvalid_b = 0;
  endtask

  task automatic wait_idle(input bit sel);
    int n = 0;
    while ((sel ? busy_b : busy_a) && n < 3000) begin @(posedge clk); #1; n++; end
    if (n >= 3000) chk("idle_timeout", 32'd0, 32'd1);
    chk("idle_mreq_ready", {31'd0, sel ? mready_b : mready_a}, 32'd1);
  endtask

  initial begin
    int n;
    @(posedge clk); #1;
    chk("rst_mreq_ready", {31'd0, mready_a}, 32'd1);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_cyc", {31'd0, cyc_a}, 32'd0);
    chk("rst_wready", {31'd0, wready_a}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid_a}, 32'd0);
    chk("rst_adr_dat_rdata", adr_a | dat_a | {24'd0, rdata_a}, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // Single-word 32-bit write
    exp_wb_a.push_back('{1'b1, 32'h10, 32'h4433_2211});
    issue(0, mk(1, 0, 2'd2, 8'd0, 32'h10));
    put_byte(0, 8'h11); put_byte(0, 8'h22); put_byte(0, 8'h33); put_byte(0, 8'h44);
    wait_idle(0);

    // Three byte reads with address increment across 0xFF
    rdw_a.push_back(32'hA1); rdw_a.push_back(32'hB2); rdw_a.push_back(32'hC3);
    exp_wb_a.push_back('{1'b0, 32'hFE, 32'h0});
    exp_wb_a.push_back('{1'b0, 32'hFF, 32'h0});
    exp_wb_a.push_back('{1'b0, 32'h100, 32'h0});
    exp_rd_a.push_back(8'hA1); exp_rd_a.push_back(8'hB2); exp_rd_a.push_back(8'hC3);
    issue(0, mk(0, 1, 2'd0, 8'd2, 32'hFE));
    wait_idle(0);

    // Halfword reads, no increment, consumer stalls 5 cycles
    rdw_a.push_back(32'hFFFF_1234); rdw_a.push_back(32'hEEEE_5678);
    exp_wb_a.push_back('{1'b0, 32'h40, 32'h0});
    exp_wb_a.push_back('{1'b0, 32'h40, 32'h0});
    exp_rd_a.push_back(8'h34); exp_rd_a.push_back(8'h12);
    exp_rd_a.push_back(8'h78); exp_rd_a.push_back(8'h56);
    rready_a = 0; dly_a = 2;
    issue(0, mk(0, 0, 2'd1, 8'd1, 32'h40));
    n = 0;
    while (!rvalid_a && n < 1000) begin @(posedge clk); #1; n++; end
    if (n >= 1000) chk("rvalid_wait_timeout", 32'd0, 32'd1);
    repeat (5) @(posedge clk);
    #1 rready_a = 1; dly_a = 0;
    wait_idle(0);

    // Timeout on instance b: no ack
    ack_en_b = 0;
    exp_wb_b.push_back('{1'b0, 32'h20, 32'h0});
    exp_rd_b.push_back(8'h00);
    issue(1, mk(0, 0, 2'd0, 8'd0, 32'h20));
    wait_idle(1);
    chk("tmo_stb_cycles", len_b, 32'd4);
    chk("tmo_err_pulses", err_cnt_b, 32'd1);

    // Ack on the expiry cycle counts as ack
    ack_en_b = 1; dly_b = 3;
    rdw_b.push_back(32'hDEAD_BEEF);
    exp_wb_b.push_back('{1'b0, 32'h21, 32'h0});
    exp_rd_b.push_back(8'hEF); exp_rd_b.push_back(8'hBE);
    exp_rd_b.push_back(8'hAD); exp_rd_b.push_back(8'hDE);
    issue(1, mk(0, 0, 2'd3, 8'd0, 32'h21));
    wait_idle(1);
    chk("late_ack_stb_cycles", len_b, 32'd4);
    chk("late_ack_no_err", err_cnt_b, 32'd1);
    dly_b = 0;

    // 8-bit address wrap on writes
    exp_wb_b.push_back('{1'b1, 32'hFF, 32'h5A});
    exp_wb_b.push_back('{1'b1, 32'h00, 32'hA5});
    issue(1, mk(1, 1, 2'd0, 8'd1, 32'h1FF));
    put_byte(1, 8'h5A); put_byte(1, 8'hA5);
    wait_idle(1);

    // Reset during write collection, then a clean halfword write
    issue(0, mk(1, 0, 2'd2, 8'd0, 32'h30));
    put_byte(0, 8'h01); put_byte(0, 8'h02);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_mreq_ready", {31'd0, mready_a}, 32'd1);
    chk("midrst_busy", {31'd0, busy_a}, 32'd0);
    chk("midrst_wready", {31'd0, wready_a}, 32'd0);
    chk("midrst_cyc", {31'd0, cyc_a}, 32'd0);
    repeat (5) @(posedge clk); #1;
    exp_wb_a.push_back('{1'b1, 32'h31, 32'h0000_BEEF});
    issue(0, mk(1, 0, 2'd1, 8'd0, 32'h31));
    put_byte(0, 8'hEF); put_byte(0, 8'hBE);
    wait_idle(0);

    repeat (3) @(posedge clk); #1;
    chk("a_wb_queue_empty", exp_wb_a.size(), 32'd0);
    chk("a_rd_queue_empty", exp_rd_a.size(), 32'd0);
    chk("b_wb_queue_empty", exp_wb_b.size(), 32'd0);
    chk("b_rd_queue_empty", exp_rd_b.size(), 32'd0);
    chk("a_no_timeouts", err_cnt_a, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
